mul_ctrl: RTL

Sequencing controller for the EXE-stage combinational multiplier. It accepts M-extension multiply operations from the issue logic over a valid/ready handshake and registers the operands. It holds them stable on the multiplier inputs for a fixed settling window, captures the 32-bit result, and presents it to writeback over a second valid/ready handshake. It also provides pipeline flush, stall generation and a completed-operation counter.

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_ctrl_if.sv | 26 ++
 rtl/mul_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the EXE-stage multiply sequencing controller.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    localparam int unsigned MUL_LATENCY = 2;

endpackage

// File: rtl/mul_ctrl_if.sv
// Request (issue) and response (writeback) handshakes of the multiply controller.
interface mul_ctrl_if;

    logic        MC_req_valid;
    logic        MC_req_ready;
    logic [31:0] MC_opra;
    logic [31:0] MC_oprb;
    logic [2:0]  MC_funct3;
    logic [4:0]  MC_rd;
    logic        MC_resp_valid;
    logic        MC_resp_ready;
    logic [31:0] MC_result;
    logic [4:0]  MC_resp_rd;

    // master: issue/writeback side; slave: the controller
    modport master (
        output MC_req_valid, MC_opra, MC_oprb, MC_funct3, MC_rd, MC_resp_ready,
        input  MC_req_ready, MC_resp_valid, MC_result, MC_resp_rd
    );

    modport slave (
        input  MC_req_valid, MC_opra, MC_oprb, MC_funct3, MC_rd, MC_resp_ready,
        output MC_req_ready, MC_resp_valid, MC_result, MC_resp_rd
    );

endinterface

// File: rtl/mul_ctrl.sv
// Holds operands on the combinational multiplier for LATENCY cycles, captures the
// product and returns it over a valid/ready handshake; supports flush and op counting.
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned LATENCY = MUL_LATENCY,
    parameter int unsigned CNT_W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mul_ctrl_if.slave    mc,
    input  logic         MC_flush,
    output logic         MC_stall,
    output logic [31:0]  MC_op_count,
    output logic [31:0]  MUL_OPRA,
    output logic [31:0]  MUL_OPRB,
    output logic [2:0]   MUL_funct3,
    input  logic [31:0]  MUL_result
);

    if (LATENCY < 1 || LATENCY > 15 || (64'd1 << CNT_W) <= 64'(LATENCY)) begin : g_bad_param
        $error("mul_ctrl: LATENCY must be 1..15 and fit in CNT_W bits");
    end

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      opra_q, oprb_q, result_q, op_count_q;
    logic [1:0]       f3_q;
    logic [4:0]       rd_q, resp_rd_q;
    logic             req_ready, load, capture, count_inc;
    logic             unused_f3;

    // funct3 bit 2 selects DIV/REM, never a multiply, so it is dropped
    assign unused_f3 = mc.MC_funct3[2];

    assign req_ready = !MC_flush &&
                       (state_q == IDLE || (state_q == DONE && mc.MC_resp_ready));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        capture   = 1'b0;
        count_inc = 1'b0;
        if (MC_flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mc.MC_req_valid) begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                        load    = 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        capture = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (mc.MC_resp_ready) begin
                        count_inc = 1'b1;
                        if (mc.MC_req_valid) begin
                            state_d = BUSY;
                            cnt_d   = CNT_W'(LATENCY - 1);
                            load    = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            opra_q     <= '0;
            oprb_q     <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            result_q   <= '0;
            resp_rd_q  <= '0;
            op_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                opra_q <= mc.MC_opra;
                oprb_q <= mc.MC_oprb;
                f3_q   <= mc.MC_funct3[1:0];
                rd_q   <= mc.MC_rd;
            end
            if (capture) begin
                result_q  <= MUL_result;
                resp_rd_q <= rd_q;
            end
            if (count_inc) begin
                op_count_q <= op_count_q + 32'd1;
            end
        end
    end

    assign mc.MC_req_ready  = req_ready;
    assign mc.MC_resp_valid = (state_q == DONE);
    assign mc.MC_result     = result_q;
    assign mc.MC_resp_rd    = resp_rd_q;
    assign MC_stall         = mc.MC_req_valid && !req_ready;
    assign MC_op_count      = op_count_q;
    assign MUL_OPRA         = opra_q;
    assign MUL_OPRB         = oprb_q;
    assign MUL_funct3       = {1'b0, f3_q};

endmodule
